// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_scan_display
//  Description : Iterative double-dabble binary-to-BCD converter driving a
//                multiplexed 4-digit common-anode 7-segment display.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_scan_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] value,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] c_refresh_last = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [9:0]  r_last_value, w_last_next;
    logic [9:0]  r_shift, w_shift_next;
    logic [15:0] r_scratch, w_scratch_next;
    logic [3:0]  r_bit_cnt, w_bit_cnt_next;
    logic [15:0] r_digits, w_digits_next;
    logic        r_busy, w_busy_next;
    logic [15:0] w_adj;

    logic [CNT_W-1:0] r_refresh_cnt;
    logic [1:0]       r_scan_idx;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic [3:0]       w_digit;
    logic             w_blank;
    logic [6:0]       w_seg_code;

    // Add-3 correction on every BCD nibble before the shift
    for (genvar i = 0; i < 4; i++) begin : g_adj
        assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ?
                                 r_scratch[4*i +: 4] + 4'd3 : r_scratch[4*i +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_value <= '0;
            r_shift      <= '0;
            r_scratch    <= '0;
            r_bit_cnt    <= '0;
            r_digits     <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_value <= w_last_next;
            r_shift      <= w_shift_next;
            r_scratch    <= w_scratch_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_digits     <= w_digits_next;
            r_busy       <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_last_next    = r_last_value;
        w_shift_next   = r_shift;
        w_scratch_next = r_scratch;
        w_bit_cnt_next = r_bit_cnt;
        w_digits_next  = r_digits;
        w_busy_next    = r_busy;
        case (r_state)
            S_IDLE: begin
                if (value != r_last_value) begin
                    w_shift_next   = value;
                    w_last_next    = value;
                    w_scratch_next = '0;
                    w_bit_cnt_next = '0;
                    w_busy_next    = 1'b1;
                    w_state_next   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {w_scratch_next, w_shift_next} = {w_adj[14:0], r_shift, 1'b0};
                w_bit_cnt_next = r_bit_cnt + 4'd1;
                if (r_bit_cnt == 4'd9) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // Digits only ever change here, so the display never shows a partial result
                w_digits_next = r_scratch;
                w_busy_next   = 1'b0;
                w_state_next  = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_digit = r_digits[3:0];
        w_blank = 1'b0;
        case (r_scan_idx)
            2'd0: begin
                w_digit = r_digits[3:0];
                w_blank = 1'b0;
            end
            2'd1: begin
                w_digit = r_digits[7:4];
                w_blank = (BLANK_LZ != 0) && (r_digits[15:4] == 12'd0);
            end
            2'd2: begin
                w_digit = r_digits[11:8];
                w_blank = (BLANK_LZ != 0) && (r_digits[15:8] == 8'd0);
            end
            default: begin
                w_digit = r_digits[15:12];
                w_blank = (BLANK_LZ != 0) && (r_digits[15:12] == 4'd0);
            end
        endcase
    end

    always_comb begin
        w_seg_code = 7'b1111111;
        case (w_digit)
            4'd0: w_seg_code = 7'b1000000;
            4'd1: w_seg_code = 7'b1111001;
            4'd2: w_seg_code = 7'b0100100;
            4'd3: w_seg_code = 7'b0110000;
            4'd4: w_seg_code = 7'b0011001;
            4'd5: w_seg_code = 7'b0010010;
            4'd6: w_seg_code = 7'b0000010;
            4'd7: w_seg_code = 7'b1111000;
            4'd8: w_seg_code = 7'b0000000;
            4'd9: w_seg_code = 7'b0010000;
            default: w_seg_code = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= '0;
            r_an          <= 4'b1111;
            r_seg         <= 7'b1111111;
        end else begin
            if (r_refresh_cnt == c_refresh_last) begin
                r_refresh_cnt <= '0;
                r_scan_idx    <= r_scan_idx + 2'd1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
            r_an  <= w_blank ? 4'b1111 : ~(4'b0001 << r_scan_idx);
            r_seg <= w_blank ? 7'b1111111 : w_seg_code;
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = 1'b1;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_scan_display
//  Description : Directed self-checking bench for bcd_scan_display, two
//                instances (leading-zero blanking on and off), REFRESH_DIV=4.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_scan_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] value = '0;
    logic [3:0] an_b, an_a;
    logic [6:0] seg_b, seg_a;
    logic       dp_b, dp_a, busy_b, busy_a;
    int         edge_cnt = 0;
    int         n_vec = 0;
    int         n_miss = 0;

    always #5 clk = ~clk;

    bcd_scan_display #(.REFRESH_DIV(4), .BLANK_LZ(1)) u_dut_blz (
        .clk(clk), .rst_n(rst_n), .value(value),
        .an(an_b), .seg(seg_b), .dp(dp_b), .busy(busy_b)
    );

    bcd_scan_display #(.REFRESH_DIV(4), .BLANK_LZ(0)) u_dut_all (
        .clk(clk), .rst_n(rst_n), .value(value),
        .an(an_a), .seg(seg_a), .dp(dp_a), .busy(busy_a)
    );

    // Posedges since reset release; outputs after edge k show slot ((k-1)/4)%4
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {an, seg} while number n is displayed and the scan is past edge cnt
    function automatic logic [10:0] exp_scan(input int cnt, input int n, input bit blz);
        int s;
        int d [4];
        bit blank;
        s = ((cnt - 1) / 4) % 4;
        d[0] = n % 10;
        d[1] = (n / 10) % 10;
        d[2] = (n / 100) % 10;
        d[3] = n / 1000;
        blank = 1'b0;
        if (blz) begin
            if (s == 3) blank = (d[3] == 0);
            if (s == 2) blank = (d[3] == 0) && (d[2] == 0);
            if (s == 1) blank = (d[3] == 0) && (d[2] == 0) && (d[1] == 0);
        end
        if (blank) return 11'h7FF;
        return {~(4'b0001 << s), seg_code(d[s])};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check(tag, {busy_b, dp_b, an_b, seg_b}, {1'b0, 1'b1, 4'hF, 7'h7F});
        check(tag, {busy_a, dp_a, an_a, seg_a}, {1'b0, 1'b1, 4'hF, 7'h7F});
    endtask

    // Apply v (prev is what is currently shown); optionally switch to v2 after
    // sample chg, then check busy and the scan every cycle for ncyc cycles.
    task automatic run_conv(input int v, input int prev, input int v2, input int chg, input int ncyc);
        bit conv1, conv2, bexp;
        int dexp;
        conv1 = (v != prev);
        conv2 = conv1 && (chg > 0) && (v2 != v);
        value = 10'(v);
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (chg > 0 && k == chg) value = 10'(v2);
            bexp = (conv1 && k <= 11) || (conv2 && k >= 13 && k <= 23);
            if (conv2 && k >= 25)      dexp = v2;
            else if (conv1 && k >= 13) dexp = v;
            else                       dexp = prev;
            check("busy", {14'd0, busy_b, busy_a}, {14'd0, bexp, bexp});
            check("scan_blz", {4'd0, dp_b, an_b, seg_b}, {4'd0, 1'b1, exp_scan(edge_cnt, dexp, 1'b1)});
            check("scan_all", {4'd0, dp_a, an_a, seg_a}, {4'd0, 1'b1, exp_scan(edge_cnt, dexp, 1'b0)});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        value = 10'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        check_reset_outputs("reset_release");
        @(negedge clk);

        run_conv(0, 0, 0, 0, 32);             // idle after reset, "0" only
        run_conv(1023, 0, 0, 0, 28);          // 1,0,2,3
        run_conv(205, 1023, 0, 0, 28);        // embedded zero kept, d3 blanked
        run_conv(100, 205, 999, 2, 44);       // change while converting

        // Asynchronous reset in the middle of a conversion
        value = 10'd512;
        repeat (3) @(negedge clk);
        check("busy_pre_rst", {15'd0, busy_b}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("rst_release2");
        run_conv(512, 0, 0, 0, 28);

        for (int v = 0; v < 1024; v++) begin
            run_conv(v, (v == 0) ? 512 : v - 1, 0, 0, 28);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
